ls259: RTL



---
 rtl/ttl_pkg.sv | 12 +
 rtl/ls259_dec.sv | 14 +
 rtl/ls259.sv | 56 +++++
 3 files changed

// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL-recreation addressable/decoder parts.
// Mode encodings are indexed as {_clr, _g}.
package ttl_pkg;

  typedef enum logic [1:0] {
    MODE_DEMUX = 2'b00,
    MODE_CLEAR = 2'b01,
    MODE_LATCH = 2'b10,
    MODE_MEM   = 2'b11
  } mode_e;

endpackage

// File: rtl/ls259_dec.sv
// Combinational 3-to-8 one-hot address decoder with enable.
// Produces the per-bit write strobes for the ls259 register bank.
module ls259_dec (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] strobe
);

  always_comb begin
    strobe = '0;
    if (en) strobe[sel] = 1'b1;
  end

endmodule

// File: rtl/ls259.sv
// Clocked model of the 74LS259 8-bit addressable latch: one data bit is
// steered into one of eight registered outputs, with demux and clear modes.
module ls259 import ttl_pkg::*; #(
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic clk,
  input  logic reset,
  input  logic _g,
  input  logic _clr,
  input  logic sel_a,
  input  logic sel_b,
  input  logic sel_c,
  input  logic d,
  output logic q0,
  output logic q1,
  output logic q2,
  output logic q3,
  output logic q4,
  output logic q5,
  output logic q6,
  output logic q7
);

  logic [7:0] q;
  logic [7:0] q_next;
  logic [7:0] strobe;
  mode_e      mode;

  assign mode = mode_e'({_clr, _g});

  // Strobes are only needed in the two modes with _g low (latch and demux).
  ls259_dec u_dec (
    .en     (~_g),
    .sel    ({sel_c, sel_b, sel_a}),
    .strobe (strobe)
  );

  always_comb begin
    q_next = q;
    case (mode)
      MODE_LATCH: q_next = (q & ~strobe) | (strobe & {8{d}});
      MODE_MEM:   q_next = q;
      MODE_DEMUX: q_next = strobe & {8{d}};
      MODE_CLEAR: q_next = '0;
      default:    q_next = q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= RESET_VALUE;
    else       q <= q_next;
  end

  assign {q7, q6, q5, q4, q3, q2, q1, q0} = q;

endmodule
